// File: rtl/cp_wb_ldalign.sv
// Write-back stage with variable-latency load handling.
// ALU results are registered straight into the RF write port. Loads park the
// stage in a wait state, stalling EX, until the data memory responds. The
// response word is then aligned, extended and written back.
module cp_wb_ldalign #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RF_INDEX_WIDTH = 5,
  parameter bit          ZERO_REG_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned OFF_W         = $clog2(DATA_WIDTH / 8)
) (
  input  logic                      iClk,
  input  logic                      iReset_n,
  input  logic [DATA_WIDTH-1:0]     iEX_WB_Write_RF_Data,
  input  logic [RF_INDEX_WIDTH-1:0] iEX_WB_Write_RF_Address,
  input  logic                      iEX_WB_Write_RF_Enable,
  input  logic                      iEX_WB_Is_Load,
  input  logic [1:0]                iEX_WB_Load_Size,
  input  logic                      iEX_WB_Load_Signed,
  input  logic [OFF_W-1:0]          iEX_WB_Load_Offset,
  input  logic                      iDMEM_Rsp_Valid,
  input  logic [DATA_WIDTH-1:0]     iDMEM_Rsp_Data,
  output logic                      oWB_Stall,
  output logic                      oWB_RF_Writeback_Enable,
  output logic [RF_INDEX_WIDTH-1:0] oWB_RF_Write_Addr,
  output logic [DATA_WIDTH-1:0]     oWB_RF_Write_Data,
  output logic [CNT_WIDTH-1:0]      oWB_Retire_Count
);

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e                    state_q;
  logic                      we_q;
  logic [RF_INDEX_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [CNT_WIDTH-1:0]      cnt_q;

  // Attributes of the outstanding load, captured when it leaves EX.
  logic [RF_INDEX_WIDTH-1:0] ld_addr_q;
  logic [1:0]                ld_size_q;
  logic                      ld_signed_q;
  logic [OFF_W-1:0]          ld_off_q;

  logic                      ex_to_zero;
  logic                      ld_to_zero;
  logic [OFF_W-1:0]          lane;
  logic [7:0]                byte_f;
  logic [15:0]               half_f;
  logic [DATA_WIDTH-1:0]     aligned;

  assign ex_to_zero = ZERO_REG_EN && (iEX_WB_Write_RF_Address == '0);
  assign ld_to_zero = ZERO_REG_EN && (ld_addr_q == '0);

  // Select the addressed byte/half lane of the response and extend it.
  always_comb begin
    lane = ld_off_q;
    if (ld_size_q == 2'b01) lane[0] = 1'b0;  // halves are always even-aligned
    byte_f  = iDMEM_Rsp_Data[{lane, 3'b000} +: 8];
    half_f  = iDMEM_Rsp_Data[{lane, 3'b000} +: 16];
    aligned = iDMEM_Rsp_Data;
    unique case (ld_size_q)
      2'b00: begin
        aligned      = {DATA_WIDTH{ld_signed_q & byte_f[7]}};
        aligned[7:0] = byte_f;
      end
      2'b01: begin
        aligned       = {DATA_WIDTH{ld_signed_q & half_f[15]}};
        aligned[15:0] = half_f;
      end
      default: aligned = iDMEM_Rsp_Data;
    endcase
  end

  // State machine, RF write port registers and saturating retire counter.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      ld_addr_q   <= '0;
      ld_size_q   <= 2'b00;
      ld_signed_q <= 1'b0;
      ld_off_q    <= '0;
    end else begin
      we_q <= 1'b0;
      // Counts the write strobe that is visible during the cycle just ending.
      if (we_q && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      unique case (state_q)
        StIdle: begin
          if (iEX_WB_Write_RF_Enable) begin
            if (iEX_WB_Is_Load) begin
              ld_addr_q   <= iEX_WB_Write_RF_Address;
              ld_size_q   <= iEX_WB_Load_Size;
              ld_signed_q <= iEX_WB_Load_Signed;
              ld_off_q    <= iEX_WB_Load_Offset;
              state_q     <= StLoadWait;
            end else if (!ex_to_zero) begin
              we_q   <= 1'b1;
              addr_q <= iEX_WB_Write_RF_Address;
              data_q <= iEX_WB_Write_RF_Data;
            end
          end
        end
        StLoadWait: begin
          if (iDMEM_Rsp_Valid) begin
            state_q <= StIdle;
            // A load to r0 still consumes its response but writes nothing.
            if (!ld_to_zero) begin
              we_q   <= 1'b1;
              addr_q <= ld_addr_q;
              data_q <= aligned;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oWB_Stall               = (state_q == StLoadWait);
  assign oWB_RF_Writeback_Enable = we_q;
  assign oWB_RF_Write_Addr       = addr_q;
  assign oWB_RF_Write_Data       = data_q;
  assign oWB_Retire_Count        = cnt_q;

endmodule

// File: tb/tb_cp_wb_ldalign.sv
// Bench for cp_wb_ldalign: directed stimulus, a transaction-level reference
// model compared every cycle, and literal expectations at key points.
module tb_cp_wb_ldalign;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] wdata = '0;
  logic [4:0]  waddr = '0;
  logic        en = 1'b0;
  logic        ld = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [1:0]  off = 2'b00;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_d = '0;

  logic        stall, we, stall_s, we_s;
  logic [4:0]  addr, addr_s;
  logic [31:0] data, data_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cp_wb_ldalign dut (
    .iClk(clk), .iReset_n(rst_n),
    .iEX_WB_Write_RF_Data(wdata), .iEX_WB_Write_RF_Address(waddr),
    .iEX_WB_Write_RF_Enable(en), .iEX_WB_Is_Load(ld),
    .iEX_WB_Load_Size(size), .iEX_WB_Load_Signed(sgn), .iEX_WB_Load_Offset(off),
    .iDMEM_Rsp_Valid(rsp_v), .iDMEM_Rsp_Data(rsp_d),
    .oWB_Stall(stall), .oWB_RF_Writeback_Enable(we),
    .oWB_RF_Write_Addr(addr), .oWB_RF_Write_Data(data), .oWB_Retire_Count(cnt)
  );

  cp_wb_ldalign #(.CNT_WIDTH(2)) dut_s (
    .iClk(clk), .iReset_n(rst_n),
    .iEX_WB_Write_RF_Data(wdata), .iEX_WB_Write_RF_Address(waddr),
    .iEX_WB_Write_RF_Enable(en), .iEX_WB_Is_Load(ld),
    .iEX_WB_Load_Size(size), .iEX_WB_Load_Signed(sgn), .iEX_WB_Load_Offset(off),
    .iDMEM_Rsp_Valid(rsp_v), .iDMEM_Rsp_Data(rsp_d),
    .oWB_Stall(stall_s), .oWB_RF_Writeback_Enable(we_s),
    .oWB_RF_Write_Addr(addr_s), .oWB_RF_Write_Data(data_s), .oWB_Retire_Count(cnt_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Load result by plain arithmetic: pick the field, then reinterpret as signed.
  function automatic logic [31:0] exp_align(input logic [31:0] w, input logic [1:0] sz,
                                            input int o, input bit s);
    longint v;
    int bits;
    if (sz == 2'b00) bits = 8;
    else if (sz == 2'b01) begin
      bits = 16;
      o = o - (o % 2);
    end else return w;
    v = longint'(w >> (8 * o)) % (longint'(1) << bits);
    if (s && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // Reference model: one pending-load record plus the expected write port.
  bit          m_busy;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;
  logic [4:0]  p_addr;
  logic [1:0]  p_size;
  int          p_off;
  bit          p_sgn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0;
    end else begin
      if (m_we) m_cnt++;
      m_we = 0;
      if (!m_busy) begin
        if (en && ld) begin
          m_busy = 1; p_addr = waddr; p_size = size; p_off = int'(off); p_sgn = sgn;
        end else if (en && waddr != 0) begin
          m_we = 1; m_addr = waddr; m_data = wdata;
        end
      end else if (rsp_v) begin
        m_busy = 0;
        if (p_addr != 0) begin
          m_we = 1; m_addr = p_addr; m_data = exp_align(rsp_d, p_size, p_off, p_sgn);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 64'(stall), 64'(m_busy));
      check("we", 64'(we), 64'(m_we));
      check("addr", 64'(addr), 64'(m_addr));
      check("data", 64'(data), 64'(m_data));
      check("count", 64'(cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
      check("stall_small", 64'(stall_s), 64'(m_busy));
      check("we_small", 64'(we_s), 64'(m_we));
      check("count_small", 64'(cnt_s), 64'((m_cnt > 3) ? 3 : m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    en = 1; ld = 0; waddr = a; wdata = d;
  endtask

  task automatic load(input logic [4:0] a, input logic [1:0] sz, input logic [1:0] o,
                      input logic s);
    en = 1; ld = 1; waddr = a; size = sz; off = o; sgn = s;
  endtask

  task automatic idle();
    en = 0; ld = 0; rsp_v = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // Pin the reference alignment function to hand-computed values.
    check("model_sbyte", 64'(exp_align(32'h80FF_FF00, 2'b00, 3, 1'b1)), 64'h0000_0000_FFFF_FF80);
    check("model_uhalf", 64'(exp_align(32'hABCD_8001, 2'b01, 1, 1'b0)), 64'h0000_0000_0000_8001);
    check("model_shalf", 64'(exp_align(32'h8000_1234, 2'b01, 2, 1'b1)), 64'h0000_0000_FFFF_8000);
    check("model_word", 64'(exp_align(32'h1122_3344, 2'b10, 3, 1'b1)), 64'h0000_0000_1122_3344);

    #3 rst_n = 0;
    chk_en = 1;
    repeat (2) step();
    @(negedge clk);
    check("rst_data", 64'(data), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    step();
    rst_n = 1;

    // Back-to-back ALU writes.
    alu(5'd3, 32'h1234_5678); step();
    alu(5'd4, 32'hDEAD_BEEF); step();
    @(negedge clk);
    check("alu2_data", 64'(data), 64'hDEAD_BEEF);
    check("alu2_addr", 64'(addr), 64'd4);
    idle(); step();
    @(negedge clk);
    check("alu_count", 64'(cnt), 64'd2);

    // Signed byte load, response after three stall cycles.
    load(5'd5, 2'b00, 2'd3, 1'b1); step();
    idle(); step();
    step();
    rsp_v = 1; rsp_d = 32'h80FF_FF00; step();
    rsp_v = 0;
    @(negedge clk);
    check("sbyte_data", 64'(data), 64'hFFFF_FF80);
    check("sbyte_stall", 64'(stall), 64'h0);

    // Half loads with minimum latency.
    load(5'd6, 2'b01, 2'd1, 1'b0); step();
    idle(); rsp_v = 1; rsp_d = 32'hABCD_8001; step();
    @(negedge clk);
    check("uhalf_data", 64'(data), 64'h0000_8001);
    load(5'd7, 2'b01, 2'd2, 1'b1); step();
    idle(); rsp_v = 1; rsp_d = 32'h8000_1234; step();
    @(negedge clk);
    check("shalf_data", 64'(data), 64'hFFFF_8000);

    // Writes to r0 are dropped, loads to r0 still stall.
    alu(5'd0, 32'h0000_0055); step();
    @(negedge clk);
    check("r0_alu_we", 64'(we), 64'h0);
    load(5'd0, 2'b10, 2'd0, 1'b0); step();
    idle(); step();
    @(negedge clk);
    check("r0_ld_stall", 64'(stall), 64'h1);
    rsp_v = 1; rsp_d = 32'h9999_9999; step();
    rsp_v = 0;
    @(negedge clk);
    check("r0_ld_data", 64'(data), 64'hFFFF_8000);
    check("r0_count", 64'(cnt), 64'd5);

    // ALU op held in EX across a stall is written once, after the load.
    load(5'd8, 2'b10, 2'd0, 1'b0); step();
    alu(5'd9, 32'hCAFE_F00D); step();
    rsp_v = 1; rsp_d = 32'h1122_3344; step();
    rsp_v = 0;
    @(negedge clk);
    check("held_ld_data", 64'(data), 64'h1122_3344);
    step();
    idle();
    @(negedge clk);
    check("held_alu_data", 64'(data), 64'hCAFE_F00D);
    step();
    @(negedge clk);
    check("held_once_we", 64'(we), 64'h0);

    // Stray response in IDLE.
    rsp_v = 1; rsp_d = 32'h7777_7777; step();
    rsp_v = 0;
    @(negedge clk);
    check("stray_we", 64'(we), 64'h0);

    // Reset while waiting for a load; a later response must be ignored.
    load(5'd10, 2'b10, 2'd0, 1'b0); step();
    idle(); step();
    rst_n = 0;
    #2;
    check("midrst_stall", 64'(stall), 64'h0);
    step();
    rst_n = 1;
    rsp_v = 1; rsp_d = 32'h5555_AAAA; step();
    rsp_v = 0;
    @(negedge clk);
    check("midrst_we", 64'(we), 64'h0);

    // Five writes: wide counter reads 5, two-bit counter saturates at 3.
    for (int i = 1; i <= 5; i++) begin
      alu(5'(i), 32'(i * 16'h0101));
      step();
    end
    idle(); step();
    step();
    @(negedge clk);
    check("sat_small", 64'(cnt_s), 64'd3);
    check("sat_wide", 64'(cnt), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
